// File: rtl/systolic_pkg.sv
// systolic_pkg: defaults shared by the systolic array and its edge blocks.
//   DATA_WIDTH : width of one partial sum (PE out_down width)
//   NUM_COLS   : number of array columns
//   ROWS_CNT_W : width of the popped-row counter
//   col_idx()  : bit offset of column `col` inside a packed row bus
package systolic_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int NUM_COLS   = 4;
    localparam int ROWS_CNT_W = 16;

    // Bit offset of a column slice inside a packed row (column 0 at the LSBs).
    function automatic int col_idx(input int col, input int width);
        return col * width;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word fall-through synchronous FIFO.
//   clk   : rising-edge clock
//   reset : synchronous, active-low; clears pointers, count and storage
//   flush : synchronous; empties the FIFO (storage kept), suppresses push/pop
//   push  : write din (accepted when not full, or full with a pop)
//   pop   : drop the head entry (ignored when empty)
//   din   : write data
//   dout  : head entry, read combinationally from storage
//   count : number of stored entries, 0..DEPTH
//   full  : count == DEPTH
//   empty : count == 0
module sync_fifo_fwft #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok_s, pop_ok_s;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == {CNT_W{1'b0}});
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Qualify push/pop and compute next pointers and occupancy.
    always_comb begin
        pop_ok_s  = pop && !empty && !flush;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push_ok_s = push && (!full || pop_ok_s) && !flush;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Row storage; zeroed on reset so the idle head reads as 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/systolic_drain.sv
// systolic_drain: bottom-edge receiver of the systolic array. Realigns the
// skewed column outputs of the last PE row into full rows, queues them in a
// FWFT FIFO and hands them downstream over valid/ready. Rows arriving while
// the FIFO is full (and not popping) are dropped and flagged.
//   clk        : rising-edge clock
//   reset      : synchronous, active-low
//   clear      : synchronous flush of FIFO, in-flight rows and overflow
//   col_data   : bottom-row out_down values, column j at [j*DATA_WIDTH +: DATA_WIDTH]
//   row_strobe : column 0 of a row valid now; column j valid j cycles later
//   out_row    : head-of-FIFO row, same packing as col_data
//   out_valid  : out_row holds a valid row
//   out_ready  : downstream accepts the row
//   overflow   : sticky, a row was dropped
//   rows_out   : count of rows popped, wraps
module systolic_drain
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = systolic_pkg::DATA_WIDTH,
    parameter int NUM_COLS   = systolic_pkg::NUM_COLS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic [NUM_COLS*DATA_WIDTH-1:0] col_data,
    input  logic                           row_strobe,
    output logic [NUM_COLS*DATA_WIDTH-1:0] out_row,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           overflow,
    output logic [ROWS_CNT_W-1:0]          rows_out
);

    localparam int ROW_W = NUM_COLS * DATA_WIDTH;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_COLS-2:0]   vld_q, vld_d;
    logic                  row_aligned_s;
    logic [ROW_W-1:0]      row_assembled_s;
    logic                  push_s, pop_s, drop_s;
    logic                  overflow_q, overflow_d;
    logic [ROWS_CNT_W-1:0] rows_out_q, rows_out_d;
    logic                  fifo_full_s, fifo_empty_s;
    logic [CNT_W-1:0]      fifo_count_s;

    // Column j waits NUM_COLS-1-j cycles so every column lands together with
    // the live last column. Data stages carry no reset or clear.
    for (genvar j = 0; j < NUM_COLS - 1; j++) begin : g_deskew
        localparam int DLY = NUM_COLS - 1 - j;
        logic [DATA_WIDTH-1:0] pipe_q [DLY];

        // Per-column delay line.
        always_ff @(posedge clk) begin
            pipe_q[0] <= col_data[col_idx(j, DATA_WIDTH) +: DATA_WIDTH];
            for (int k = 1; k < DLY; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
        end

        assign row_assembled_s[col_idx(j, DATA_WIDTH) +: DATA_WIDTH] = pipe_q[DLY-1];
    end

    assign row_assembled_s[col_idx(NUM_COLS-1, DATA_WIDTH) +: DATA_WIDTH] =
        col_data[col_idx(NUM_COLS-1, DATA_WIDTH) +: DATA_WIDTH];

    assign row_aligned_s = vld_q[NUM_COLS-2];

    // Strobe shift, handshake qualification, overflow and pop counter.
    always_comb begin
        vld_d = {(NUM_COLS-1){1'b0}};
        if (clear) begin
            vld_d = {(NUM_COLS-1){1'b0}};
        end else begin
            vld_d[0] = row_strobe;
            for (int k = 1; k < NUM_COLS - 1; k++) begin
                vld_d[k] = vld_q[k-1];
            end
        end

        pop_s  = out_ready && !fifo_empty_s && !clear;
        push_s = row_aligned_s && !clear;
        drop_s = row_aligned_s && fifo_full_s && !pop_s && !clear;

        if (clear) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q | drop_s;
        end

        if (pop_s) begin
            rows_out_d = rows_out_q + ROWS_CNT_W'(1);
        end else begin
            rows_out_d = rows_out_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_q      <= {(NUM_COLS-1){1'b0}};
            overflow_q <= 1'b0;
            rows_out_q <= {ROWS_CNT_W{1'b0}};
        end else begin
            vld_q      <= vld_d;
            overflow_q <= overflow_d;
            rows_out_q <= rows_out_d;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (ROW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (clear),
        .push  (push_s),
        .pop   (pop_s),
        .din   (row_assembled_s),
        .dout  (out_row),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign out_valid = (fifo_count_s != {CNT_W{1'b0}});
    assign overflow  = overflow_q;
    assign rows_out  = rows_out_q;

endmodule

// File: tb/tb_systolic_drain.sv
// tb_systolic_drain: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a queue-based row model.
module tb_systolic_drain;

    localparam int NC    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int BW    = NC * DW;
    localparam int MAXC  = 8192;
    localparam int SEQN  = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          clear = 1'b0;
    logic          row_strobe = 1'b0;
    logic          out_ready = 1'b0;
    logic [BW-1:0] col_data = '0;
    logic [BW-1:0] out_row;
    logic          out_valid;
    logic          overflow;
    logic [15:0]   rows_out;

    always #5 clk = ~clk;

    systolic_drain #(.DATA_WIDTH(DW), .NUM_COLS(NC), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .col_data   (col_data),
        .row_strobe (row_strobe),
        .out_row    (out_row),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .rows_out   (rows_out)
    );

    int tests = 0;
    int fails = 0;

    // Behavioural model: input history, queue of complete rows, flags.
    logic [BW-1:0] hist_col [MAXC];
    bit            hist_strb [MAXC];
    logic [BW-1:0] mq [$];
    bit            m_ovf = 1'b0;
    int            m_rows = 0;
    int            last_kill = -1;
    int            cyc = 0;
    bit            started = 1'b0;

    // Outputs sampled in the most recent cycle.
    bit            s_valid, s_ovf;
    logic [BW-1:0] s_row;
    logic [15:0]   s_rows;

    // Directed sequence tables and per-cycle samples.
    bit            d_strb [SEQN];
    int            d_tag  [SEQN];
    bit            d_rstn [SEQN];
    bit            d_clr  [SEQN];
    bit            d_rdy  [SEQN];
    bit            sv     [SEQN];
    bit            sovf   [SEQN];
    logic [BW-1:0] srow   [SEQN];
    logic [15:0]   srows  [SEQN];

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic tick(input bit rst_n, input bit clr, input bit strb, input bit rdy,
                        input logic [BW-1:0] cols);
        int            t;
        bit            aligned;
        logic [BW-1:0] row;
        @(posedge clk);
        #1;
        reset      = rst_n;
        clear      = clr;
        row_strobe = strb;
        out_ready  = rdy;
        col_data   = cols;
        @(negedge clk);
        s_valid = out_valid;
        s_ovf   = overflow;
        s_row   = out_row;
        s_rows  = rows_out;
        if (started) begin
            check("out_valid", BW'(out_valid), BW'(mq.size() != 0));
            if (mq.size() != 0) check("out_row", out_row, mq[0]);
            check("overflow", BW'(overflow), BW'(m_ovf));
            check("rows_out", BW'(rows_out), BW'(m_rows));
        end
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget: got %0d cycles, limit %0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        hist_col[cyc]  = cols;
        hist_strb[cyc] = strb;
        if (!rst_n) begin
            mq.delete();
            m_ovf     = 1'b0;
            m_rows    = 0;
            last_kill = cyc;
            started   = 1'b1;
        end else if (clr) begin
            mq.delete();
            m_ovf     = 1'b0;
            last_kill = cyc;
        end else begin
            // A row strobed at t is complete NC-1 cycles later unless a
            // reset/clear happened anywhere in between.
            t       = cyc - (NC - 1);
            aligned = (t >= 0) && hist_strb[t] && (last_kill < t);
            if (mq.size() != 0 && rdy) begin
                void'(mq.pop_front());
                m_rows = (m_rows + 1) % 65536;
            end
            if (aligned) begin
                for (int j = 0; j < NC; j++) row[j*DW +: DW] = hist_col[t+j][j*DW +: DW];
                if (mq.size() < DEPTH) mq.push_back(row);
                else m_ovf = 1'b1;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, 1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic seq_init();
        for (int c = 0; c < SEQN; c++) begin
            d_strb[c] = 1'b0;
            d_tag[c]  = 0;
            d_rstn[c] = 1'b1;
            d_clr[c]  = 1'b0;
            d_rdy[c]  = 1'b1;
        end
    endtask

    // Column j at cycle c carries tag*16+j of the row strobed at c-j, else 0xDEAD.
    task automatic run_seq(input int n);
        logic [BW-1:0] cols;
        for (int c = 0; c < n; c++) begin
            for (int j = 0; j < NC; j++) begin
                if (c - j >= 0 && d_strb[c-j]) cols[j*DW +: DW] = 16'(d_tag[c-j] * 16 + j);
                else cols[j*DW +: DW] = 16'hDEAD;
            end
            tick(d_rstn[c], d_clr[c], d_strb[c], d_rdy[c], cols);
            sv[c]    = s_valid;
            sovf[c]  = s_ovf;
            srow[c]  = s_row;
            srows[c] = s_rows;
        end
    endtask

    function automatic logic [BW-1:0] rowv(input int r);
        logic [BW-1:0] v;
        for (int j = 0; j < NC; j++) v[j*DW +: DW] = 16'(r * 16 + j);
        return v;
    endfunction

    int rdy_pct;

    initial begin
        // 1: single row after reset
        do_reset();
        seq_init();
        d_strb[0] = 1'b1; d_tag[0] = 32'h100;
        run_seq(7);
        check("t1_reset_valid", BW'(sv[0]), BW'(0));
        check("t1_reset_rows", BW'(srows[0]), BW'(0));
        check("t1_valid_c3", BW'(sv[3]), BW'(0));
        check("t1_valid_c4", BW'(sv[4]), BW'(1));
        check("t1_row_c4", srow[4], 64'h1003_1002_1001_1000);
        check("t1_valid_c5", BW'(sv[5]), BW'(0));
        check("t1_rows_c5", BW'(srows[5]), BW'(1));

        // 2: back-to-back rows
        do_reset();
        seq_init();
        for (int r = 0; r < 4; r++) begin d_strb[r] = 1'b1; d_tag[r] = r; end
        run_seq(10);
        check("t2_valid_c3", BW'(sv[3]), BW'(0));
        for (int r = 0; r < 4; r++) begin
            check("t2_valid", BW'(sv[4+r]), BW'(1));
            check("t2_row", srow[4+r], rowv(r));
        end
        check("t2_row0_lit", srow[4], 64'h0003_0002_0001_0000);
        check("t2_row3_lit", srow[7], 64'h0033_0032_0031_0030);
        check("t2_valid_c8", BW'(sv[8]), BW'(0));
        check("t2_rows_c8", BW'(srows[8]), BW'(4));
        check("t2_ovf_c8", BW'(sovf[8]), BW'(0));

        // 3: overflow with downstream stalled
        do_reset();
        seq_init();
        for (int r = 0; r < 6; r++) begin d_strb[r] = 1'b1; d_tag[r] = r; end
        for (int c = 0; c < 10; c++) d_rdy[c] = 1'b0;
        run_seq(16);
        check("t3_ovf_c7", BW'(sovf[7]), BW'(0));
        check("t3_ovf_c8", BW'(sovf[8]), BW'(1));
        check("t3_head_c9", srow[9], rowv(0));
        for (int r = 0; r < 4; r++) begin
            check("t3_valid", BW'(sv[10+r]), BW'(1));
            check("t3_row", srow[10+r], rowv(r));
        end
        check("t3_valid_c14", BW'(sv[14]), BW'(0));
        check("t3_ovf_c14", BW'(sovf[14]), BW'(1));
        check("t3_rows_c14", BW'(srows[14]), BW'(4));

        // 4: full FIFO with push and pop in the same cycle
        do_reset();
        seq_init();
        for (int r = 0; r < 5; r++) begin d_strb[r] = 1'b1; d_tag[r] = r; end
        for (int c = 0; c < 7; c++) d_rdy[c] = 1'b0;
        run_seq(14);
        check("t4_row_A", srow[7], rowv(0));
        for (int r = 1; r < 5; r++) begin
            check("t4_valid", BW'(sv[7+r]), BW'(1));
            check("t4_row", srow[7+r], rowv(r));
        end
        check("t4_valid_c12", BW'(sv[12]), BW'(0));
        check("t4_ovf_c12", BW'(sovf[12]), BW'(0));
        check("t4_rows_c12", BW'(srows[12]), BW'(5));

        // 5: reset mid-row (no pre-reset, rows_out starts at 5)
        seq_init();
        d_strb[0] = 1'b1; d_tag[0] = 7;
        d_strb[5] = 1'b1; d_tag[5] = 9;
        d_rstn[2] = 1'b0;
        run_seq(12);
        check("t5_rows_c1", BW'(srows[1]), BW'(5));
        check("t5_rows_c3", BW'(srows[3]), BW'(0));
        check("t5_ovf_c3", BW'(sovf[3]), BW'(0));
        check("t5_row_c3", srow[3], BW'(0));
        for (int c = 3; c < 9; c++) check("t5_no_valid", BW'(sv[c]), BW'(0));
        check("t5_valid_c9", BW'(sv[9]), BW'(1));
        check("t5_row_c9", srow[9], rowv(9));

        // 6: clear with rows queued, overflow set and a row in flight
        do_reset();
        seq_init();
        for (int r = 0; r < 5; r++) begin d_strb[r] = 1'b1; d_tag[r] = r; end
        for (int c = 0; c < SEQN; c++) d_rdy[c] = (c == 8 || c == 9);
        d_strb[10] = 1'b1; d_tag[10] = 5;
        d_clr[11]  = 1'b1;
        run_seq(18);
        check("t6_valid_c10", BW'(sv[10]), BW'(1));
        check("t6_row_c10", srow[10], rowv(2));
        check("t6_ovf_c10", BW'(sovf[10]), BW'(1));
        check("t6_ovf_c12", BW'(sovf[12]), BW'(0));
        check("t6_rows_c12", BW'(srows[12]), BW'(2));
        for (int c = 12; c < 18; c++) check("t6_no_valid", BW'(sv[c]), BW'(0));

        // Randomized traffic with epochs of varying downstream readiness.
        rdy_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) rdy_pct = $urandom_range(0, 100);
            tick($urandom_range(0, 299) != 0, $urandom_range(0, 149) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 99) < rdy_pct,
                 {$urandom, $urandom});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/systolic_drain.md
Name: systolic_drain

Overview:
- Receiver at the bottom edge of the systolic matrix-multiply array.
- Captures the column partial-sum outputs of the last PE row, which arrive skewed by one cycle per column.
- Realigns each skewed diagonal into a full result row, buffers rows in a small FIFO, and hands them downstream over a valid/ready handshake.
- The array cannot stall, so a row that arrives when the FIFO is full is dropped and flagged.

Parameters:
- DATA_WIDTH, 16, width of one partial sum (matches PE out_down width).
- NUM_COLS, 4, number of array columns; must be >= 2.
- FIFO_DEPTH, 4, result-row FIFO entries; must be a power of 2 and >= 2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- clear  in  1  synchronous flush: empties the FIFO and in-flight valids, clears overflow. Data registers are not cleared.
- col_data  in  NUM_COLS*DATA_WIDTH  bottom-row out_down values; column j is in bits [j*DATA_WIDTH +: DATA_WIDTH].
- row_strobe  in  1  column 0 of a result row is valid this cycle; column j of the same row is valid exactly j cycles later.
- out_row  out  NUM_COLS*DATA_WIDTH  head-of-FIFO result row, same packing as col_data.
- out_valid  out  1  out_row holds a valid row.
- out_ready  in  1  downstream accepts the row.
- overflow  out  1  sticky: at least one row was dropped.
- rows_out  out  16  count of rows popped; wraps from 0xFFFF to 0.

Behaviour:
- Reset (reset==0 at the clock edge) drives:
  - out_valid=0, overflow=0, rows_out=0.
  - FIFO pointers and count to 0.
  - All deskew valid bits to 0.
  - out_row = 0 (FIFO storage cleared).
- Reset has priority over clear. Both act in the same edge, including mid-row: partially deskewed rows are discarded and never emitted.
- Deskew:
  - Column j passes through NUM_COLS-1-j pipeline registers. Column NUM_COLS-1 is used combinationally with zero delay.
  - row_strobe passes through a NUM_COLS-1 stage valid shift register, giving row_aligned.
  - A row is complete when row_aligned==1. At that edge the assembled row is the delayed columns 0..N-2 plus the live column N-1.
- Multiple rows may be in flight; row_strobe may be high on consecutive cycles (one row per cycle).
- Latency: row_strobe high in cycle t. The row is pushed at the edge ending cycle t+NUM_COLS-1. If the FIFO was empty, out_valid is high in cycle t+NUM_COLS.
- The FIFO is first-word fall-through: out_row and out_valid reflect the head entry combinationally from storage. out_valid = (count != 0).
- Pop occurs when out_valid && out_ready at the edge; rows_out increments by 1 (mod 2^16).
- Push rules:
  - Push when row_aligned and (count < FIFO_DEPTH, or a pop occurs in the same cycle).
  - Full with a simultaneous pop: the push succeeds and count is unchanged.
  - Full without a pop: the row is dropped, overflow is set to 1 (sticky), and FIFO contents are unchanged.
- Push and pop in the same cycle when not full: count is unchanged and both pointers advance.
- Empty with row_aligned: the row is pushed. It is not bypassed, so out_valid rises the next cycle.
- Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH and uses log2(FIFO_DEPTH)+1 bits.
- clear==1 (reset inactive):
  - Sets count and pointers to 0, deskew valids to 0, and overflow to 0.
  - rows_out is held.
  - A push or pop in the same cycle is suppressed.
- out_row is don't-care when out_valid==0.
- No arithmetic is done on the data; values pass through bit-exact.

Decomposition:
- Shared package systolic_pkg:
  - DATA_WIDTH and NUM_COLS defaults shared with the PE array.
  - ROWS_CNT_W=16.
  - A col_idx helper function for the slice offset.
- One natural sub-module, sync_fifo_fwft:
  - Parameters: width, depth.
  - Ports: push, pop, din, dout, count, full, empty, flush.
- The deskew shift registers and the overflow/counter logic stay in systolic_drain.

Test Plan:
1. Reset then single row (NUM_COLS=4, DATA_WIDTH=16): row_strobe at cycle 0; col j driven with 0x1000+j at cycle j, other cycles 0xDEAD -> out_valid rises at cycle 4; out_row = {0x1003,0x1002,0x1001,0x1000}; with out_ready=1, rows_out=1 after the pop.
2. Back-to-back rows: row_strobe on cycles 0..3, row r col j = r*16+j at cycle r+j, out_ready=1 -> four consecutive out_valid cycles 4..7 with rows in order, no overflow, rows_out=4.
3. Overflow (FIFO_DEPTH=4): out_ready=0, six rows strobed -> count=4, overflow=1, out_row still shows row 0. Then out_ready=1 -> exactly rows 0..3 emitted and overflow stays 1.
4. Full with simultaneous pop: FIFO full with rows A-D, row E aligns in the same cycle as a pop -> no overflow; output order is B, C, D, E.
5. Reset mid-operation: row_strobe at cycle 0, reset=0 at cycle 2 -> no out_valid for that row; all outputs at reset values at cycle 3; a new row strobed at cycle 5 emits correctly at cycle 9.
6. clear: with 2 rows queued and overflow=1, pulse clear -> next cycle out_valid=0, overflow=0, rows_out held; a row in flight during clear is not emitted.
